// File: rtl/kb_ascii_sequencer.sv
// PS/2 make/break/extended parser feeding a scan-to-ASCII converter, with
// typematic/unknown-key filtering and a first-word-fall-through output FIFO.
module kb_ascii_sequencer #(
  parameter int ADDR_W       = 3,
  parameter bit REPEAT_EN    = 1'b0,
  parameter bit DROP_UNKNOWN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] key_code,
  input  logic [7:0] ascii_in,
  input  logic       rd_req,
  output logic [7:0] ascii_out,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic [2:0] state_dbg,
  output logic       held_valid_dbg
);

  // Handshake: scan_valid is a one-cycle strobe per byte with no back-pressure;
  // the consumer pops the head shown on ascii_out by raising rd_req while empty=0.

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BRK     = 3'd1,
    EXT     = 3'd2,
    EXT_BRK = 3'd3,
    PUSH    = 3'd4
  } state_t;

  state_t            state;
  logic [7:0]        held_code;
  logic              held_valid;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              in_push;
  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic              lost;

  assign empty          = (count == '0);
  assign full           = (count == FULL_CNT);
  assign ascii_out      = mem[rd_ptr];
  assign state_dbg      = state;
  assign held_valid_dbg = held_valid;

  always_comb begin
    in_push = (state == PUSH);
    accept  = in_push && !(DROP_UNKNOWN && (ascii_in == 8'h2A));
    // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
    wr_en   = accept && (!full || rd_req);
    rd_en   = rd_req && !empty;
    lost    = (accept && !wr_en) || (in_push && scan_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      key_code   <= 8'h00;
      held_code  <= 8'h00;
      held_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (lost)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (scan_valid) begin
            if (scan_code == 8'hF0)
              state <= BRK;
            else if (scan_code == 8'hE0)
              state <= EXT;
            else if (REPEAT_EN || !held_valid || (scan_code != held_code)) begin
              key_code   <= scan_code;
              held_code  <= scan_code;
              held_valid <= 1'b1;
              state      <= PUSH;
            end
          end
        end
        BRK: begin
          if (scan_valid) begin
            if (scan_code == held_code)
              held_valid <= 1'b0;
            state <= IDLE;
          end
        end
        EXT: begin
          if (scan_valid)
            state <= (scan_code == 8'hF0) ? EXT_BRK : IDLE;
        end
        EXT_BRK: begin
          if (scan_valid)
            state <= IDLE;
        end
        PUSH:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'h00;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= ascii_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_kb_ascii_sequencer.sv
// Directed bench for kb_ascii_sequencer: three instances (default, repeat-enabled,
// unknown-passing) share stimulus; each has its own converter model.
module tb_kb_ascii_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       rd_req = 1'b0;
  logic       clr_overflow = 1'b0;

  logic [7:0] a_key, a_ascii_in, a_out;
  logic       a_empty, a_full, a_ovf, a_held;
  logic [2:0] a_state;
  logic [7:0] r_key, r_ascii_in, r_out;
  logic       r_empty, r_full, r_ovf, r_held;
  logic [2:0] r_state;
  logic [7:0] u_key, u_ascii_in, u_out;
  logic       u_empty, u_full, u_ovf, u_held;
  logic [2:0] u_state;

  int total = 0;
  int bad = 0;

  logic [7:0] scan_tab [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
  logic [7:0] chr_tab  [9] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};

  always #5 clk = ~clk;

  function automatic logic [7:0] conv(input logic [7:0] k);
    case (k)
      8'h1C: conv = 8'h41;
      8'h32: conv = 8'h42;
      8'h21: conv = 8'h43;
      8'h23: conv = 8'h44;
      8'h24: conv = 8'h45;
      8'h2B: conv = 8'h46;
      8'h34: conv = 8'h47;
      8'h33: conv = 8'h48;
      8'h43: conv = 8'h49;
      default: conv = 8'h2A;
    endcase
  endfunction

  assign a_ascii_in = conv(a_key);
  assign r_ascii_in = conv(r_key);
  assign u_ascii_in = conv(u_key);

  kb_ascii_sequencer #(.ADDR_W(3), .REPEAT_EN(1'b0), .DROP_UNKNOWN(1'b1)) dut (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .key_code(a_key), .ascii_in(a_ascii_in), .rd_req(rd_req), .ascii_out(a_out),
    .empty(a_empty), .full(a_full), .overflow(a_ovf), .clr_overflow(clr_overflow),
    .state_dbg(a_state), .held_valid_dbg(a_held));

  kb_ascii_sequencer #(.ADDR_W(3), .REPEAT_EN(1'b1), .DROP_UNKNOWN(1'b1)) dut_rep (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .key_code(r_key), .ascii_in(r_ascii_in), .rd_req(rd_req), .ascii_out(r_out),
    .empty(r_empty), .full(r_full), .overflow(r_ovf), .clr_overflow(clr_overflow),
    .state_dbg(r_state), .held_valid_dbg(r_held));

  kb_ascii_sequencer #(.ADDR_W(3), .REPEAT_EN(1'b0), .DROP_UNKNOWN(1'b0)) dut_unk (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .key_code(u_key), .ascii_in(u_ascii_in), .rd_req(rd_req), .ascii_out(u_out),
    .empty(u_empty), .full(u_full), .overflow(u_ovf), .clr_overflow(clr_overflow),
    .state_dbg(u_state), .held_valid_dbg(u_held));

  // Driver tasks: all called at a negedge and return at a negedge.
  task automatic do_reset();
    reset = 1'b1; scan_valid = 1'b0; rd_req = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    scan_code = b; scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_one();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset();
    total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b exp=1", a_empty); end
    total++; if (a_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b exp=0", a_full); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0b exp=0", a_ovf); end
    total++; if (a_key !== 8'h00) begin bad++; $display("FAIL rst_key got=%h exp=00", a_key); end
    total++; if (a_out !== 8'h00) begin bad++; $display("FAIL rst_out got=%h exp=00", a_out); end
    total++; if (a_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", a_state); end
    total++; if (a_held !== 1'b0) begin bad++; $display("FAIL rst_held got=%0b exp=0", a_held); end
  endtask

  task automatic test_make_break();
    do_reset();
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    total++; if (a_empty !== 1'b0) begin bad++; $display("FAIL mb_nonempty got=%0b exp=0", a_empty); end
    total++; if (a_out !== 8'h41) begin bad++; $display("FAIL mb_head got=%h exp=41", a_out); end
    total++; if (a_held !== 1'b0) begin bad++; $display("FAIL mb_held got=%0b exp=0", a_held); end
    total++; if (a_state !== 3'd0) begin bad++; $display("FAIL mb_state got=%0d exp=0", a_state); end
    pop_one();
    total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL mb_single got=%0b exp=1", a_empty); end
  endtask

  task automatic test_typematic();
    logic [7:0] seq [6] = '{8'h2B, 8'h2B, 8'h2B, 8'hF0, 8'h2B, 8'h2B};
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(seq[i]);
    for (int i = 0; i < 4; i++) begin
      total++; if (r_out !== 8'h46 || r_empty !== 1'b0) begin bad++; $display("FAIL typ_rep%0d got=%h/%0b exp=46/0", i, r_out, r_empty); end
      if (i < 2) begin
        total++; if (a_out !== 8'h46 || a_empty !== 1'b0) begin bad++; $display("FAIL typ_norep%0d got=%h/%0b exp=46/0", i, a_out, a_empty); end
      end
      pop_one();
      if (i == 1) begin
        total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL typ_norep_cnt got=%0b exp=1", a_empty); end
      end
    end
    total++; if (r_empty !== 1'b1) begin bad++; $display("FAIL typ_rep_cnt got=%0b exp=1", r_empty); end
  endtask

  task automatic test_ext_unknown();
    logic [7:0] seq [6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h05};
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(seq[i]);
    total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL ext_drop_empty got=%0b exp=1", a_empty); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL ext_drop_ovf got=%0b exp=0", a_ovf); end
    total++; if (a_key !== 8'h05) begin bad++; $display("FAIL ext_key got=%h exp=05", a_key); end
    total++; if (u_empty !== 1'b0 || u_out !== 8'h2A) begin bad++; $display("FAIL ext_unk_push got=%h/%0b exp=2a/0", u_out, u_empty); end
    pop_one();
    total++; if (u_empty !== 1'b1) begin bad++; $display("FAIL ext_unk_single got=%0b exp=1", u_empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_byte(scan_tab[i]); send_byte(8'hF0); send_byte(scan_tab[i]);
      if (i == 7) begin
        total++; if (a_full !== 1'b1 || a_ovf !== 1'b0) begin bad++; $display("FAIL full8 got=%0b/%0b exp=1/0", a_full, a_ovf); end
      end
    end
    total++; if (a_full !== 1'b1 || a_ovf !== 1'b1) begin bad++; $display("FAIL full9 got=%0b/%0b exp=1/1", a_full, a_ovf); end
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL full_clr got=%0b exp=0", a_ovf); end
    for (int i = 0; i < 8; i++) begin
      total++; if (a_out !== chr_tab[i]) begin bad++; $display("FAIL full_pop%0d got=%h exp=%h", i, a_out, chr_tab[i]); end
      pop_one();
    end
    total++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin bad++; $display("FAIL full_drain got=%0b/%0b exp=1/0", a_empty, a_full); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(scan_tab[i]);
    total++; if (a_full !== 1'b1) begin bad++; $display("FAIL pp_prefull got=%0b exp=1", a_full); end
    scan_code = scan_tab[8]; scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    total++; if (a_full !== 1'b1 || a_ovf !== 1'b0) begin bad++; $display("FAIL pp_flags got=%0b/%0b exp=1/0", a_full, a_ovf); end
    for (int i = 1; i < 9; i++) begin
      total++; if (a_out !== chr_tab[i]) begin bad++; $display("FAIL pp_pop%0d got=%h exp=%h", i, a_out, chr_tab[i]); end
      pop_one();
    end
    total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL pp_drain got=%0b exp=1", a_empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    scan_code = 8'h1C; scan_valid = 1'b1;
    @(negedge clk);
    scan_code = 8'h32;
    @(negedge clk);
    scan_valid = 1'b0;
    @(negedge clk);
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL b2b_ovf got=%0b exp=1", a_ovf); end
    total++; if (a_out !== 8'h41 || a_empty !== 1'b0) begin bad++; $display("FAIL b2b_head got=%h/%0b exp=41/0", a_out, a_empty); end
    pop_one();
    total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL b2b_single got=%0b exp=1", a_empty); end
  endtask

  task automatic test_reset_mid_break();
    do_reset();
    send_byte(8'h1C); pop_one();
    send_byte(8'hF0);
    total++; if (a_state !== 3'd1) begin bad++; $display("FAIL rmb_brk got=%0d exp=1", a_state); end
    do_reset();
    total++; if (a_state !== 3'd0 || a_empty !== 1'b1) begin bad++; $display("FAIL rmb_idle got=%0d/%0b exp=0/1", a_state, a_empty); end
    send_byte(8'h1C);
    total++; if (a_out !== 8'h41 || a_empty !== 1'b0) begin bad++; $display("FAIL rmb_head got=%h/%0b exp=41/0", a_out, a_empty); end
    pop_one();
    total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL rmb_single got=%0b exp=1", a_empty); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_typematic();
    test_ext_unknown();
    test_full();
    test_push_pop_full();
    test_back_to_back();
    test_reset_mid_break();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
